// File: rtl/prbs_pkg.sv
// PRBS-31 checker shared definitions: polynomial, state encoding,
// LFSR stepping helpers and per-word counter events.
package prbs_pkg;

  localparam logic [31:0] PRBS_POLY = 32'h48000000;
  localparam logic [31:0] LFSR_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_CHECK,
    ST_LOCKED
  } chk_state_e;

  typedef struct packed {
    logic       word;
    logic       word_err;
    logic [5:0] bits;
    logic       loss;
  } cnt_evt_t;

  function automatic logic [31:0] prbs_step(
    input logic [31:0] s
  );
    return {s[30:0], ^(s & PRBS_POLY)};
  endfunction

  // One received word advances the sequence by 32 bit-times.
  function automatic logic [31:0] prbs_next(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++) begin
      r = prbs_step(r);
    end
    return r;
  endfunction

  function automatic logic [5:0] popcount32(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit statistics counter: adds 0..32 per cycle, clamps at all-ones,
// synchronous clear has priority over the increment.
module sat_counter32 (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic [5:0]  inc,
  output logic [31:0] count
);

  logic [32:0] sum;

  assign sum = {1'b0, count} + {27'd0, inc};

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sum[32]) begin
      count <= '1;
    end else begin
      count <= sum[31:0];
    end
  end

endmodule

// File: rtl/prbs_error_checker.sv
// PRBS-31 receive checker: self-synchronising LFSR with lock/unlock
// hysteresis and saturating word/bit error statistics.
module prbs_error_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic        locked,
  output logic [31:0] error_bits,
  output logic [31:0] word_count,
  output logic [31:0] word_err_count,
  output logic [31:0] bit_err_count,
  output logic [31:0] lock_loss_count
);

  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);

  chk_state_e  state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  bad_q, bad_d;
  logic [31:0] err_q, err_d;
  logic [31:0] expected;
  logic [31:0] diff;
  logic        accept;
  logic        mismatch;
  logic [7:0]  good_inc;
  logic [7:0]  bad_inc;
  cnt_evt_t    evt;

  assign accept   = S_AXIS_TVALID;
  assign expected = prbs_next(lfsr_q);
  assign diff     = S_AXIS_TDATA ^ expected;
  assign mismatch = |diff;
  assign good_inc = good_q + 8'd1;
  assign bad_inc  = bad_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_INIT;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = err_q;
    if (!enable) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SEED;
          err_d   = '0;
        end
        ST_SEED: begin
          err_d = '0;
          if (accept) begin
            lfsr_d  = S_AXIS_TDATA;
            good_d  = '0;
            bad_d   = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            err_d = diff;
            if (!mismatch) begin
              lfsr_d = expected;
              if (good_inc >= LOCK_N) begin
                good_d  = '0;
                state_d = ST_LOCKED;
              end else begin
                good_d = good_inc;
              end
            end else begin
              lfsr_d = S_AXIS_TDATA;
              good_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            // Flywheel on the prediction so a bad word cannot corrupt S.
            err_d  = diff;
            lfsr_d = expected;
            if (!mismatch) begin
              bad_d = '0;
            end else if (bad_inc >= UNLOCK_N) begin
              bad_d   = '0;
              state_d = ST_SEED;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    evt = '0;
    if (enable && accept && state_q == ST_LOCKED) begin
      evt.word     = 1'b1;
      evt.word_err = mismatch;
      evt.bits     = popcount32(diff);
      evt.loss     = mismatch && (bad_inc >= UNLOCK_N);
    end
  end

  assign S_AXIS_TREADY = 1'b1;
  assign locked        = (state_q == ST_LOCKED);
  assign error_bits    = err_q;

  sat_counter32 u_word_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (clear),
    .inc     ({5'd0, evt.word}),
    .count   (word_count)
  );

  sat_counter32 u_word_err_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (clear),
    .inc     ({5'd0, evt.word_err}),
    .count   (word_err_count)
  );

  sat_counter32 u_bit_err_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (clear),
    .inc     (evt.bits),
    .count   (bit_err_count)
  );

  sat_counter32 u_loss_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (clear),
    .inc     ({5'd0, evt.loss}),
    .count   (lock_loss_count)
  );

endmodule

// File: tb/tb_prbs_error_checker.sv
// Self-checking bench for prbs_error_checker: directed scenarios plus a
// randomized stream, compared every cycle against a behavioural model.
module tb_prbs_error_checker;

  localparam int LC = 4;
  localparam int UC = 8;
  localparam longint SAT = 64'h00000000FFFFFFFF;
  localparam int M_IDLE = 0;
  localparam int M_SEED = 1;
  localparam int M_CHECK = 2;
  localparam int M_LOCKED = 3;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        clear;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        locked;
  logic [31:0] error_bits;
  logic [31:0] word_count;
  logic [31:0] word_err_count;
  logic [31:0] bit_err_count;
  logic [31:0] lock_loss_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int          ms;
  logic [31:0] mlfsr;
  int          mgood;
  int          mbad;
  logic [31:0] merr;
  longint      mwc, mwec, mbec, mllc;

  logic [31:0] gen;

  always #5 clk = ~clk;

  prbs_error_checker #(
    .LOCK_COUNT   (LC),
    .UNLOCK_COUNT (UC)
  ) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .enable          (enable),
    .clear           (clear),
    .S_AXIS_TDATA    (tdata),
    .S_AXIS_TVALID   (tvalid),
    .S_AXIS_TREADY   (tready),
    .locked          (locked),
    .error_bits      (error_bits),
    .word_count      (word_count),
    .word_err_count  (word_err_count),
    .bit_err_count   (bit_err_count),
    .lock_loss_count (lock_loss_count)
  );

  // Bit-serial PRBS-31 (x^31 + x^28 + 1), one word = 32 bit-times.
  function automatic logic [31:0] bstep(input logic [31:0] s);
    logic fb;
    fb = s[30] ^ s[27];
    return (s << 1) | {31'd0, fb};
  endfunction

  function automatic logic [31:0] bnext(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    repeat (32) r = bstep(r);
    return r;
  endfunction

  function automatic longint sadd(input longint a, input longint b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [31:0] e;
    logic [31:0] d;
    longint iw, ie, ib, il;
    iw = 0; ie = 0; ib = 0; il = 0;
    if (!aresetn) begin
      ms = M_IDLE; mlfsr = 32'hFFFFFFFF; mgood = 0; mbad = 0;
      merr = 0; mwc = 0; mwec = 0; mbec = 0; mllc = 0;
    end else begin
      e = bnext(mlfsr);
      d = tdata ^ e;
      if (!enable) begin
        ms = M_IDLE; mgood = 0; mbad = 0; merr = 0;
      end else if (ms == M_IDLE) begin
        ms = M_SEED; merr = 0;
      end else if (ms == M_SEED) begin
        merr = 0;
        if (tvalid) begin
          mlfsr = tdata; mgood = 0; mbad = 0; ms = M_CHECK;
        end
      end else if (ms == M_CHECK) begin
        if (tvalid) begin
          merr = d;
          if (d == 0) begin
            mlfsr = e;
            mgood++;
            if (mgood == LC) begin
              ms = M_LOCKED; mgood = 0;
            end
          end else begin
            mlfsr = tdata; mgood = 0;
          end
        end
      end else if (tvalid) begin
        merr = d;
        mlfsr = e;
        iw = 1;
        ie = (d != 0) ? 1 : 0;
        ib = $countones(d);
        mbad = (d != 0) ? mbad + 1 : 0;
        if (mbad == UC) begin
          ms = M_SEED; mbad = 0; il = 1;
        end
      end
      if (clear) begin
        mwc = 0; mwec = 0; mbec = 0; mllc = 0;
      end else begin
        mwc = sadd(mwc, iw);
        mwec = sadd(mwec, ie);
        mbec = sadd(mbec, ib);
        mllc = sadd(mllc, il);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("tready", {31'd0, tready}, 32'd1);
      chk("locked", {31'd0, locked}, {31'd0, ms == M_LOCKED});
      chk("error_bits", error_bits, merr);
      chk("word_count", word_count, mwc[31:0]);
      chk("word_err_count", word_err_count, mwec[31:0]);
      chk("bit_err_count", bit_err_count, mbec[31:0]);
      chk("lock_loss_count", lock_loss_count, mllc[31:0]);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] mask);
    tvalid = v;
    if (v) begin
      tdata = gen ^ mask;
      gen = bnext(gen);
    end else begin
      tdata = $urandom;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1'b0, 32'd0);
    clear = 1'b0;
  endtask

  initial begin
    int burst;
    int r;
    logic [31:0] mask;
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0;
    tvalid = 1'b0; tdata = '0; gen = 32'h00000001;
    chk("model_next_of_1", bnext(gen), 32'h00000012);
    chk("model_step_taps", bstep(32'h48000000), 32'h90000000);
    @(posedge clk); #2;
    cyc(1'b0, 0); cyc(1'b0, 0);
    check_en = 1'b1;
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_word_count", word_count, 32'd0);
    chk("reset_error_bits", error_bits, 32'd0);

    aresetn = 1'b1; enable = 1'b1;
    cyc(1'b0, 0);
    words(4);
    chk("not_locked_after_seed_3", {31'd0, locked}, 32'd0);
    words(1);
    chk("locked_after_seed_4", {31'd0, locked}, 32'd1);
    words(100);
    chk("clean_word_count", word_count, 32'd100);
    chk("clean_word_err", word_err_count, 32'd0);
    chk("clean_bit_err", bit_err_count, 32'd0);

    words(49);
    cyc(1'b1, 32'h00000005);
    chk("single_err_bits", error_bits, 32'h00000005);
    chk("single_word_err", word_err_count, 32'd1);
    chk("single_bit_err", bit_err_count, 32'd2);
    words(1);
    chk("word51_clean", error_bits, 32'd0);
    chk("lock_held", {31'd0, locked}, 32'd1);

    pulse_clear();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'hFFFFFFFF);
    chk("burst_loss", lock_loss_count, 32'd1);
    chk("burst_unlocked", {31'd0, locked}, 32'd0);
    chk("burst_bit_err", bit_err_count, 32'd256);
    words(4);
    chk("relock_not_yet", {31'd0, locked}, 32'd0);
    words(1);
    chk("relock_5", {31'd0, locked}, 32'd1);

    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'd0);
      cyc(1'b0, 32'd0);
    end
    chk("toggle_word_count", word_count, 32'd20);

    dut.u_word_err_cnt.count = 32'hFFFFFFFE;
    mwec = 64'h00000000FFFFFFFE;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00000001);
    chk("sat_word_err", word_err_count, 32'hFFFFFFFF);
    clear = 1'b1;
    cyc(1'b1, 32'h00000100);
    clear = 1'b0;
    chk("clear_wins", word_err_count, 32'd0);
    words(3);

    aresetn = 1'b0;
    cyc(1'b1, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    chk("rst_bit_err", bit_err_count, 32'd0);
    aresetn = 1'b1;
    cyc(1'b0, 0);
    words(4);
    chk("rst_relock_not_yet", {31'd0, locked}, 32'd0);
    words(1);
    chk("rst_relock", {31'd0, locked}, 32'd1);

    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      aresetn = (r != 0);
      enable = !(r >= 1 && r <= 3);
      clear = (r >= 4 && r <= 12);
      mask = 32'd0;
      if (burst > 0) begin
        mask = $urandom | 32'h1;
        burst--;
      end else if (r >= 20 && r <= 23) begin
        burst = int'($urandom_range(5, 10));
      end else if (r >= 30 && r <= 50) begin
        mask = 32'h1 << $urandom_range(0, 31);
      end
      cyc($urandom_range(0, 3) != 0, mask);
    end
    aresetn = 1'b1; enable = 1'b1; clear = 1'b0;
    words(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
